// File: rtl/mem_pkg.sv
// Shared defaults and FSM state encoding for the memory responder.
package mem_pkg;

  localparam int AW_DEF   = 8;
  localparam int DW_DEF   = 16;
  localparam int WAIT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// 2^AW x DW storage: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read or write in IDLE,
// waits WAIT cycles in BUSY, completes in a single DONE cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int WAIT = WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  // Storage is always addressed by the latched address, so request
  // inputs changing after accept cannot disturb the access.
  mem_array #(.AW(AW), .DW(DW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state, request latching and the BUSY->DONE commit point.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memread ^ memwrite) begin
          wr_d    = memwrite;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end else if (memread && memwrite) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (wr_q) mem_we  = 1'b1;
          else      rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);
  assign err   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter AW, default 8, word-address width.
REQ-002 Parameter DW, default 16, data word width.
REQ-003 Parameter WAIT, default 2, BUSY cycles per access, legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 memread  input  1  read request from the controller, held until ready.
REQ-007 memwrite  input  1  write request from the controller, held until ready.
REQ-008 addr  input  AW  word address, sampled at accept.
REQ-009 wdata  input  DW  write data, sampled at accept.
REQ-010 rdata  output  DW  registered read data.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high while an access is in flight (BUSY or DONE).
REQ-013 err  output  1  one-cycle pulse for an illegal request.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE, with a 4-bit wait counter.
REQ-015 In IDLE, with exactly one of memread or memwrite high, the block SHALL latch addr, wdata and the operation type, load the counter with WAIT-1, and enter BUSY.
REQ-016 In IDLE, with memread and memwrite both high, the block SHALL stay in IDLE, pulse err for one cycle, and perform no access.
REQ-017 In BUSY, the counter SHALL decrement each cycle; at counter==0 the FSM SHALL enter DONE.
REQ-018 A write SHALL commit the latched wdata to the latched address on the BUSY->DONE edge.
REQ-019 A read SHALL load rdata from the latched address on the BUSY->DONE edge.
REQ-020 In DONE, ready SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-021 Total latency from the accept edge to ready high SHALL be WAIT+1 cycles.
REQ-022 Request inputs SHALL be ignored in BUSY and DONE; changes to addr or wdata after accept SHALL have no effect.
REQ-023 A request still high in the IDLE cycle after DONE SHALL be accepted as a new access (back-to-back allowed).
REQ-024 rdata SHALL hold its value until the next read completes; writes SHALL NOT change rdata.
REQ-025 Addresses SHALL use all AW bits with no wrap logic; the array depth is 2^AW.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 rst low SHALL immediately force state=IDLE, counter=0, ready=0, busy=0, err=0 and rdata=0.
REQ-028 Reset asserted mid-access SHALL abort the access; a write SHALL NOT commit unless the BUSY->DONE edge has already occurred.
REQ-029 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-030 A shared package mem_pkg SHALL hold the AW, DW and WAIT defaults and the IDLE/BUSY/DONE state encoding (2 bits).
REQ-031 The storage SHALL be a sub-module mem_array: synchronous write, combinational read, 2^AW x DW, with no reset.
REQ-032 mem_responder SHALL contain the FSM, counter, request latches and output registers.

Verification
REQ-033 Reset, then write 16'hBEEF to addr 8'h05 with WAIT=2 -> ready high on the 3rd edge after accept, busy high for 3 cycles, rdata stays 0.
REQ-034 Read addr 8'h05 -> ready after 3 cycles with rdata=16'hBEEF; rdata holds through the next 5 idle cycles.
REQ-035 memread and memwrite both high in IDLE -> err pulses one cycle, busy stays 0, no access occurs, and a read of the target address returns its prior value.
REQ-036 Write 16'h1234 to addr 8'hFF, then change addr to 8'h00 and wdata to 16'h0000 during BUSY -> addr 8'hFF reads 16'h1234 and addr 8'h00 is unchanged.
REQ-037 Assert rst during the first BUSY cycle of a write of 16'hAAAA to addr 8'h10 -> outputs go to 0 immediately and a later read of 8'h10 returns its old value.
REQ-038 Hold memread high across two accesses to 8'h01 and 8'h02 -> two ready pulses 4 cycles apart, each with the correct rdata.
